edge_event_arbiter: RTL and testbench

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

---
 rtl/edge_evt_pkg.sv | 16 +
 rtl/edge_event_arbiter_if.sv | 25 ++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/edge_event_arbiter.sv | 77 +++++++
 tb/tb_edge_event_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/edge_evt_pkg.sv
// Shared sizing and output-stage state type for the edge event arbiter.
package edge_evt_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    // Index width; a single input still needs one index bit.
    function automatic int unsigned idx_w(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Edge-pulse input / event output bundle of the edge event arbiter.
interface edge_event_arbiter_if #(
    parameter int WIDTH = edge_evt_pkg::DEF_WIDTH,
    parameter int IDX_W = edge_evt_pkg::idx_w(WIDTH)
) ();

    logic [WIDTH-1:0] pedge;
    logic             ovf_clr;
    logic             evt_ready;
    logic             evt_valid;
    logic [IDX_W-1:0] evt_idx;
    logic [WIDTH-1:0] ovf;
    logic             busy;

    modport master (
        output pedge, ovf_clr, evt_ready,
        input  evt_valid, evt_idx, ovf, busy
    );

    modport slave (
        input  pedge, ovf_clr, evt_ready,
        output evt_valid, evt_idx, ovf, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick among requests, starting at the slot after the last grant.
module rr_arbiter
    import edge_evt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req_i,
    input  logic             adv_i,
    output logic             gnt_vld_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] slot;

    // Scan WIDTH slots from ptr_q, wrapping; first set request wins.
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        sum       = '0;
        slot      = '0;
        for (int k = 0; k < WIDTH; k++) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(WIDTH)) sum = sum - (IDX_W+1)'(WIDTH);
            slot = sum[IDX_W-1:0];
            if (!gnt_vld_o && req_i[slot]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = slot;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && gnt_vld_o)
            ptr_d = (gnt_idx_o == IDX_W'(WIDTH-1)) ? '0 : gnt_idx_o + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects one-cycle edge pulses into a pending set, flags lost events and
// serialises them round-robin onto a one-entry valid/ready output stage.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = idx_w(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    edge_event_arbiter_if.slave  evt
);

    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] ovf_q, ovf_d;
    logic [WIDTH-1:0] gnt_oh;
    logic             gnt_vld, grant;
    logic [IDX_W-1:0] gnt_idx;
    out_state_e       state_q;
    logic [IDX_W-1:0] idx_q;

    // A slot frees up when the stage is empty or its event is taken now.
    assign grant = gnt_vld && ((state_q == EMPTY) || evt.evt_ready);

    rr_arbiter #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (pend_q),
        .adv_i     (grant),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        gnt_oh = '0;
        if (grant) gnt_oh[gnt_idx] = 1'b1;
    end

    // A pulse on a bit being granted re-arms it instead of counting as lost.
    assign pend_d = (pend_q & ~gnt_oh) | evt.pedge;
    assign ovf_d  = (ovf_q & {WIDTH{~evt.ovf_clr}}) | (evt.pedge & pend_q & ~gnt_oh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            idx_q   <= '0;
        end else begin
            case (state_q)
                EMPTY: if (grant) begin
                    state_q <= FULL;
                    idx_q   <= gnt_idx;
                end
                FULL: begin
                    if (grant)               idx_q   <= gnt_idx;
                    else if (evt.evt_ready)  state_q <= EMPTY;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign evt.evt_valid = (state_q == FULL);
    assign evt.evt_idx   = idx_q;
    assign evt.ovf       = ovf_q;
    assign evt.busy      = (|pend_q) | (state_q == FULL);

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed scenarios plus a randomized run against a behavioural event model.
module tb_edge_event_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    edge_event_arbiter_if #(.WIDTH(8)) bus ();

    edge_event_arbiter #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .evt   (bus.slave)
    );

    // Reference model: a set of pending events, a lost-event mask, the slot
    // to search from next and the single presented event.
    logic [7:0] m_pend, m_ovf;
    int         m_ptr;
    logic       m_valid;
    logic [2:0] m_idx;

    task automatic model_reset();
        m_pend = '0; m_ovf = '0; m_ptr = 0; m_valid = 1'b0; m_idx = '0;
    endtask

    task automatic model_step(input logic [7:0] pe, input logic clr, input logic rdy);
        int g;
        logic [7:0] np, no;
        g = -1;
        if (!m_valid || rdy)
            for (int k = 0; k < 8; k++) begin
                int j;
                j = (m_ptr + k) % 8;
                if (g < 0 && m_pend[j]) g = j;
            end
        no = clr ? 8'h00 : m_ovf;
        np = '0;
        for (int i = 0; i < 8; i++) begin
            if (pe[i] && m_pend[i] && i != g) no[i] = 1'b1;
            np[i] = (m_pend[i] && i != g) || pe[i];
        end
        m_pend = np;
        m_ovf  = no;
        if (g >= 0) begin
            m_valid = 1'b1;
            m_idx   = g[2:0];
            m_ptr   = (g + 1) % 8;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
    endtask

    // Advance one clock: model sees the same inputs as the DUT edge.
    task automatic step();
        model_step(bus.pedge, bus.ovf_clr, bus.evt_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.pedge = '0; bus.ovf_clr = 1'b0; bus.evt_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.pedge = '0; bus.ovf_clr = 1'b0; bus.evt_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #3;
        n_cmp++; if (bus.evt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.evt_valid); end
        n_cmp++; if (bus.evt_idx !== 3'd0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", bus.evt_idx); end
        n_cmp++; if (bus.ovf !== 8'h00) begin n_bad++; $display("FAIL reset_ovf got %h want 00", bus.ovf); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        bus.evt_ready = 1'b1;
        bus.pedge = 8'h02;
        step();
        bus.pedge = 8'h00;
        n_cmp++; if (bus.evt_valid !== 1'b0) begin n_bad++; $display("FAIL single_early got %b want 0", bus.evt_valid); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", bus.busy); end
        step();
        n_cmp++; if (bus.evt_valid !== 1'b1 || bus.evt_idx !== 3'd1)
            begin n_bad++; $display("FAIL single_evt got v=%b i=%0d want v=1 i=1", bus.evt_valid, bus.evt_idx); end
        step();
        n_cmp++; if (bus.evt_valid !== 1'b0) begin n_bad++; $display("FAIL single_once got %b want 0", bus.evt_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_idle got %b want 0", bus.busy); end
    endtask

    task automatic test_simultaneous();
        logic [2:0] want [3] = '{3'd1, 3'd2, 3'd3};
        do_reset();
        bus.evt_ready = 1'b1;
        bus.pedge = 8'h0E;
        step();
        bus.pedge = 8'h00;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (bus.evt_valid !== 1'b1 || bus.evt_idx !== want[k])
                begin n_bad++; $display("FAIL simul_%0d got v=%b i=%0d want v=1 i=%0d", k, bus.evt_valid, bus.evt_idx, want[k]); end
        end
        step();
        n_cmp++; if (bus.evt_valid !== 1'b0) begin n_bad++; $display("FAIL simul_end got %b want 0", bus.evt_valid); end
    endtask

    task automatic test_backpressure();
        int n_all, n_two;
        do_reset();
        bus.evt_ready = 1'b0;
        bus.pedge = 8'h01; step();
        bus.pedge = 8'h00; step();
        bus.pedge = 8'h04; step();
        bus.pedge = 8'h00; step();
        bus.pedge = 8'h04; step();
        bus.pedge = 8'h00;
        n_cmp++; if (bus.ovf !== 8'h04) begin n_bad++; $display("FAIL bp_ovf got %h want 04", bus.ovf); end
        n_cmp++; if (bus.evt_valid !== 1'b1 || bus.evt_idx !== 3'd0)
            begin n_bad++; $display("FAIL bp_hold got v=%b i=%0d want v=1 i=0", bus.evt_valid, bus.evt_idx); end
        bus.evt_ready = 1'b1;
        n_all = 0; n_two = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.evt_valid) begin
                n_all++;
                if (bus.evt_idx == 3'd2) n_two++;
            end
            step();
        end
        n_cmp++; if (n_two !== 1) begin n_bad++; $display("FAIL bp_idx2 got %0d events want 1", n_two); end
        n_cmp++; if (n_all !== 2) begin n_bad++; $display("FAIL bp_total got %0d events want 2", n_all); end
    endtask

    task automatic test_fairness();
        int  nev;
        bit  seen5;
        do_reset();
        bus.evt_ready = 1'b1;
        nev = 0; seen5 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            bus.pedge = (c == 3) ? 8'h21 : 8'h01;
            step();
            if (c >= 3 && !seen5 && bus.evt_valid) begin
                nev++;
                if (bus.evt_idx == 3'd5) seen5 = 1'b1;
            end
        end
        bus.pedge = 8'h00;
        n_cmp++; if (!(seen5 && nev <= 2)) begin n_bad++; $display("FAIL fair_idx5 got seen=%b after %0d grants want within 2", seen5, nev); end
        n_cmp++; if (bus.ovf[5] !== 1'b0) begin n_bad++; $display("FAIL fair_ovf5 got %b want 0", bus.ovf[5]); end
        n_cmp++; if (bus.ovf !== m_ovf) begin n_bad++; $display("FAIL fair_ovf got %h want %h", bus.ovf, m_ovf); end
    endtask

    task automatic test_clr_priority();
        do_reset();
        bus.evt_ready = 1'b0;
        bus.pedge = 8'h08; step();
        bus.pedge = 8'h00; step();
        bus.pedge = 8'h02; step();
        step();
        n_cmp++; if (bus.ovf !== 8'h02) begin n_bad++; $display("FAIL clr_pre got %h want 02", bus.ovf); end
        bus.pedge = 8'h08; step();
        bus.ovf_clr = 1'b1; step();
        bus.ovf_clr = 1'b0; bus.pedge = 8'h00;
        n_cmp++; if (bus.ovf !== 8'h08) begin n_bad++; $display("FAIL clr_prio got %h want 08", bus.ovf); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.evt_ready = 1'b0;
        bus.pedge = 8'hFF; step();
        step();
        bus.pedge = 8'h00;
        n_cmp++; if (bus.evt_valid !== 1'b1 || bus.ovf !== 8'hFE)
            begin n_bad++; $display("FAIL rmid_pre got v=%b ovf=%h want v=1 ovf=fe", bus.evt_valid, bus.ovf); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (bus.evt_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b want 0", bus.evt_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.ovf !== 8'h00) begin n_bad++; $display("FAIL rmid_ovf got %h want 00", bus.ovf); end
        #3 rst_n = 1'b1;
        bus.evt_ready = 1'b1;
        bus.pedge = 8'h10; step();
        bus.pedge = 8'h00;
        n_cmp++; if (bus.evt_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_early got %b want 0", bus.evt_valid); end
        step();
        n_cmp++; if (bus.evt_valid !== 1'b1 || bus.evt_idx !== 3'd4)
            begin n_bad++; $display("FAIL rmid_after got v=%b i=%0d want v=1 i=4", bus.evt_valid, bus.evt_idx); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bus.pedge     = (c % 50 < 5) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            bus.evt_ready = ($urandom_range(0, 3) != 0);
            bus.ovf_clr   = ($urandom_range(0, 15) == 0);
            step();
            n_cmp++; if (bus.evt_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid c=%0d got %b want %b", c, bus.evt_valid, m_valid); end
            if (m_valid) begin
                n_cmp++; if (bus.evt_idx !== m_idx) begin n_bad++; $display("FAIL rnd_idx c=%0d got %0d want %0d", c, bus.evt_idx, m_idx); end
            end
            n_cmp++; if (bus.ovf !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf c=%0d got %h want %h", c, bus.ovf, m_ovf); end
            n_cmp++; if (bus.busy !== ((|m_pend) | m_valid)) begin n_bad++; $display("FAIL rnd_busy c=%0d got %b want %b", c, bus.busy, (|m_pend) | m_valid); end
        end
        bus.pedge = '0; bus.ovf_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_fairness();
        test_clr_priority();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
